// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - ALU control codes, extended op codes and sequencer state encoding
package alu_sequencer_pkg;

  // ALU control codes (3 bits); code 3'b101 is unused by the ALU
  localparam logic [2:0] ALU_MOVE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_NOT  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  // Extended request op codes (bit 3 set)
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SHLN = 4'b1001;
  localparam logic [3:0] OP_SHRN = 4'b1010;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Reserved codes, and MUL when the multiplier is disabled, answer with an error
  function automatic logic op_is_err(input logic [3:0] op, input logic mul_en);
    logic err;
    if (op == 4'b0101) begin
      err = 1'b1;
    end else if (op == OP_MUL) begin
      err = !mul_en;
    end else if ((op == OP_SHLN) || (op == OP_SHRN)) begin
      err = 1'b0;
    end else begin
      err = op[3];
    end
    return err;
  endfunction

  // ALU code used by the single-pass path; extended ops (N=0 shift, errors) use MOVE
  function automatic logic [2:0] exec_ctl(input logic [3:0] op);
    return op[3] ? ALU_MOVE : op[2:0];
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// rtl/alu_sequencer_alu.sv - 8-bit combinational ALU driven by the sequencer
module alu_sequencer_alu #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       alu_ctl,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);
  import alu_sequencer_pkg::*;

  logic [WIDTH-1:0] sum;

  // Function select; the unused control code produces zero
  always_comb begin
    sum      = in0 + in1;
    result   = '0;
    overflow = 1'b0;
    case (alu_ctl)
      ALU_MOVE: result = in0;
      ALU_ADD: begin
        result   = sum;
        overflow = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
      end
      ALU_AND:  result = in0 & in1;
      ALU_NOT:  result = ~in0;
      ALU_NOR:  result = ~(in0 | in1);
      ALU_SLL:  result = {in0[WIDTH-2:0], 1'b0};
      ALU_SRL:  result = {1'b0, in0[WIDTH-1:1]};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer that owns and iterates the ALU
module alu_sequencer #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);
  import alu_sequencer_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] b_q, b_d;          // multiplier (shifted right per step) or shift count
  logic [WIDTH-1:0] acc_q, acc_d;      // MUL partial product
  logic [WIDTH-1:0] mcand_q, mcand_d;  // MUL multiplicand, doubled per step
  logic [WIDTH-1:0] work_q, work_d;    // operand A / shift working value
  logic [3:0]       cnt_q, cnt_d;      // ALU passes still to run after the current one
  logic             run_q, run_d;      // ALU registers hold a live pass (0 = setup cycle)
  logic [2:0]       alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0] alu_in0_q, alu_in0_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_ovf;
  logic             unused_alu_flags;
  logic             acc_err;
  logic [WIDTH-1:0] fin_res;

  // ALU pins come only from registers, so they move only on clock edges
  alu_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
    .alu_ctl  (alu_ctl_q),
    .in0      (alu_in0_q),
    .in1      (alu_in1_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  // Response zero flag is computed locally; ALU flags are not needed
  assign unused_alu_flags = alu_zero ^ alu_ovf;

  assign acc_err = op_is_err(req_op, (MUL_EN != 0));

  // Next-state, datapath write-back and next ALU pass selection
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    err_d        = err_q;
    b_d          = b_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    alu_ctl_d    = alu_ctl_q;
    alu_in0_d    = alu_in0_q;
    alu_in1_d    = alu_in1_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    fin_res      = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          err_d   = acc_err;
          b_d     = req_b;
          acc_d   = '0;
          mcand_d = req_a;
          work_d  = req_a;
          run_d   = 1'b0;
          cnt_d   = 4'd0;
          if (!acc_err && (req_op == OP_MUL)) begin
            state_d = ST_ITER;
            cnt_d   = 4'd15;                       // 8 bit-steps x 2 passes
          end else if (!acc_err && ((req_op == OP_SHLN) || (req_op == OP_SHRN))
                       && (req_b[2:0] != 3'd0)) begin
            state_d = ST_ITER;
            cnt_d   = {1'b0, req_b[2:0]} - 4'd1;
          end else begin
            state_d = ST_EXEC;                     // single op, N=0 shift, or error
          end
        end
      end

      ST_EXEC: begin
        if (!run_q) begin
          run_d     = 1'b1;
          alu_ctl_d = exec_ctl(op_q);
          alu_in0_d = work_q;
          alu_in1_d = b_q;
        end else begin
          fin_res      = err_q ? '0 : alu_result;
          rsp_result_d = fin_res;
          rsp_zero_d   = (fin_res == '0);
          rsp_err_d    = err_q;
          run_d        = 1'b0;
          state_d      = ST_RESP;
        end
      end

      ST_ITER: begin
        // Retire the pass that was in the ALU this cycle
        if (run_q) begin
          if (op_q == OP_MUL) begin
            if (cnt_q[0]) begin
              acc_d = alu_result;                  // phase 0: add-or-move into acc
            end else begin
              mcand_d = alu_result;                // phase 1: double multiplicand
              b_d     = b_q >> 1;                  // next multiplier bit to b[0]
            end
          end else begin
            work_d = alu_result;
          end
        end

        if (run_q && (cnt_q == 4'd0)) begin
          fin_res      = (op_q == OP_MUL) ? acc_d : work_d;
          rsp_result_d = fin_res;
          rsp_zero_d   = (fin_res == '0);
          rsp_err_d    = 1'b0;
          run_d        = 1'b0;
          state_d      = ST_RESP;
        end else begin
          // Load the following pass from the freshly written-back values
          if (run_q) begin
            cnt_d = cnt_q - 4'd1;
          end
          run_d = 1'b1;
          if (op_q == OP_MUL) begin
            if (cnt_d[0]) begin
              alu_ctl_d = b_d[0] ? ALU_ADD : ALU_MOVE;
              alu_in0_d = acc_d;
              alu_in1_d = mcand_d;
            end else begin
              alu_ctl_d = ALU_SLL;
              alu_in0_d = mcand_d;
              alu_in1_d = '0;
            end
          end else begin
            alu_ctl_d = (op_q == OP_SHLN) ? ALU_SLL : ALU_SRL;
            alu_in0_d = work_d;
            alu_in1_d = '0;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'd0;
      err_q        <= 1'b0;
      b_q          <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      work_q       <= '0;
      cnt_q        <= 4'd0;
      run_q        <= 1'b0;
      alu_ctl_q    <= ALU_MOVE;
      alu_in0_q    <= '0;
      alu_in1_q    <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      err_q        <= err_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_in0_q    <= alu_in0_d;
      alu_in1_q    <= alu_in1_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule
